// File: rtl/whack_pkg.sv
// -----------------------------------------------------------------------------
// whack_pkg
// Shared types and helpers for the whack-a-mole game engine.
//   game_state_t : top-level game FSM states (idle / playing / game over)
//   speed_t      : two-bit speed level selecting one of four spawn periods
//   SCORE_W      : width of the score register and port
//   ms_to_cycles : converts a millisecond interval to clock cycles
// -----------------------------------------------------------------------------
package whack_pkg;

    localparam int SCORE_W = 14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } game_state_t;

    typedef logic [1:0] speed_t;

    // Whole cycles per interval; a clock slower than 1 kHz yields 0 and the
    // caller is expected to clamp.
    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// Single-channel switch conditioner: two-flop synchroniser followed by a
// stability counter. The stable level only follows the synchronised input
// after it has differed from the current stable level for DEBOUNCE_CYC
// consecutive cycles.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   sw     : raw asynchronous switch level
//   stable : debounced switch level
//   rise   : one-cycle pulse on a debounced 0->1 transition
// -----------------------------------------------------------------------------
module sw_debounce #(
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic stable,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= sw;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            if (sync2_q == stable_q) begin
                // Any bounce back to the stable level restarts the count.
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                stable_q <= sync2_q;
                rise_q   <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign stable = stable_q;
    assign rise   = rise_q;

endmodule

// File: rtl/whack_game_core.sv
// -----------------------------------------------------------------------------
// whack_game_core
// Parametrised whack-a-mole engine: start/play/over FSM, millisecond
// prescaler driving a one-second tick and a speed-dependent spawn tick,
// up to MAX_TGT concurrent targets that expire after LIFE_TICKS spawn ticks,
// and saturating scoring from debounced switch rising edges.
//
// Optional build macro STREAK_BONUS_EN: when defined, a consecutive-hit
// streak counter is kept and a hit that brings it to a multiple of 5 scores
// +2. When undefined, every hit scores +1 and the streak port is tied to 0.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : start / restart pulse (already debounced)
//   speed_sel    : requested speed level, registered every cycle
//   sw           : raw switches, one per target channel
//   rand_pos     : free-running random value used as spawn position
//   target_led   : lit targets
//   score        : current score (saturating 0..SCORE_MAX)
//   timer        : seconds remaining
//   speed_level  : active speed level
//   playing      : game in progress
//   game_over    : game finished, waiting for start
//   hit_pulse    : one cycle per scoring hit
//   miss_pulse   : one cycle per wrong switch or target expiry
//   streak       : consecutive-hit count
// -----------------------------------------------------------------------------
module whack_game_core
    import whack_pkg::*;
#(
    parameter int N_SW         = 18,
    parameter int POS_W        = $clog2(N_SW),
    parameter int CLK_HZ       = 50_000_000,
    parameter int GAME_SECS    = 60,
    parameter int MAX_TGT      = 2,
    parameter int LIFE_TICKS   = 2,
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int SPD0_MS      = 2000,
    parameter int SPD1_MS      = 1500,
    parameter int SPD2_MS      = 1000,
    parameter int SPD3_MS      = 750,
    parameter int SCORE_MAX    = 9999
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         speed_sel,
    input  logic [N_SW-1:0]    sw,
    input  logic [POS_W-1:0]   rand_pos,
    output logic [N_SW-1:0]    target_led,
    output logic [SCORE_W-1:0] score,
    output logic [5:0]         timer,
    output logic [1:0]         speed_level,
    output logic               playing,
    output logic               game_over,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic [3:0]         streak
);

    localparam int MS_RAW = ms_to_cycles(CLK_HZ, 1);
    localparam int MS_CYC = (MS_RAW < 1) ? 1 : MS_RAW;
    localparam int PRE_W  = $clog2(MS_CYC + 1);

    localparam logic [15:0] SPD0_M1 = 16'(SPD0_MS - 1);
    localparam logic [15:0] SPD1_M1 = 16'(SPD1_MS - 1);
    localparam logic [15:0] SPD2_M1 = 16'(SPD2_MS - 1);
    localparam logic [15:0] SPD3_M1 = 16'(SPD3_MS - 1);

    localparam logic [5:0]       TIMER_INIT = 6'(GAME_SECS);
    localparam logic [SCORE_W:0] SCORE_CAP  = (SCORE_W + 1)'(SCORE_MAX);

    // ------------------------------------------------------------------
    // Switch conditioning
    // ------------------------------------------------------------------
    logic [N_SW-1:0] rise_w;
    logic [N_SW-1:0] stable_w;
    logic [N_SW-1:0] rise_ok;

    genvar gi;
    generate
        for (gi = 0; gi < N_SW; gi++) begin : g_deb
            sw_debounce #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC)
            ) u_deb (
                .clk    (clk),
                .rst_n  (rst_n),
                .sw     (sw[gi]),
                .stable (stable_w[gi]),
                .rise   (rise_w[gi])
            );
        end
    endgenerate

    // A rise always coincides with a high stable level; qualifying on both
    // keeps the edge tied to the debounced level.
    assign rise_ok = rise_w & stable_w;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    game_state_t        state_q;
    speed_t             speed_level_q;
    logic [N_SW-1:0]    target_q;
    logic [SCORE_W-1:0] score_q;
    logic [5:0]         timer_q;
    logic               playing_q;
    logic               game_over_q;
    logic               hit_q;
    logic               miss_q;

    logic [PRE_W-1:0]   pre_q;
    logic [9:0]         sec_cnt_q;
    logic [15:0]        spawn_cnt_q;

    // ------------------------------------------------------------------
    // Tick generation (runs only while playing, cleared on game entry)
    // ------------------------------------------------------------------
    logic        in_play;
    logic        ms_tick;
    logic        sec_tick;
    logic        spawn_tick;
    logic [15:0] spawn_m1;

    assign in_play = (state_q == S_PLAY);
    assign ms_tick = in_play && (pre_q == PRE_W'(MS_CYC - 1));

    always_comb begin
        case (speed_level_q)
            2'd0:    spawn_m1 = SPD0_M1;
            2'd1:    spawn_m1 = SPD1_M1;
            2'd2:    spawn_m1 = SPD2_M1;
            default: spawn_m1 = SPD3_M1;
        endcase
    end

    assign sec_tick   = ms_tick && (sec_cnt_q == 10'd999);
    // ">=" so that switching to a shorter period mid-count fires at once
    // instead of running the counter around.
    assign spawn_tick = ms_tick && (spawn_cnt_q >= spawn_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q       <= '0;
            sec_cnt_q   <= '0;
            spawn_cnt_q <= '0;
        end else if (start) begin
            pre_q       <= '0;
            sec_cnt_q   <= '0;
            spawn_cnt_q <= '0;
        end else if (in_play) begin
            pre_q <= ms_tick ? '0 : pre_q + 1'b1;
            if (ms_tick) begin
                sec_cnt_q   <= sec_tick   ? '0 : sec_cnt_q + 10'd1;
                spawn_cnt_q <= spawn_tick ? '0 : spawn_cnt_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Hit / miss classification against the pre-cycle targets
    // ------------------------------------------------------------------
    logic [N_SW-1:0]  hit_bits;
    logic [N_SW-1:0]  after_hit;
    logic             any_hit;
    logic             wrong_sw;
    logic [POS_W-1:0] spawn_pos;
    logic [5:0]       lit_cnt;
    logic             spawn_ok;
    logic [N_SW-1:0]  spawn_bits;
    logic [N_SW-1:0]  expire_bits;
    logic [N_SW-1:0]  target_d;

    assign hit_bits  = rise_ok & target_q;
    assign after_hit = target_q & ~hit_bits;
    assign any_hit   = |hit_bits;
    assign wrong_sw  = |(rise_ok & ~target_q);

    // rand_pos spans less than 2*N_SW, so one conditional subtract folds it.
    always_comb begin
        if (int'(rand_pos) >= N_SW) begin
            spawn_pos = POS_W'(int'(rand_pos) - N_SW);
        end else begin
            spawn_pos = rand_pos;
        end
    end

    always_comb begin
        lit_cnt = '0;
        for (int i = 0; i < N_SW; i++) begin
            lit_cnt = lit_cnt + {5'd0, after_hit[i]};
        end
    end

    // Occupancy is judged after hits, so a bit hit on the spawn tick is
    // re-lit fresh by the spawn.
    assign spawn_ok   = spawn_tick && (lit_cnt < 6'(MAX_TGT)) && !after_hit[spawn_pos];
    assign spawn_bits = spawn_ok ? (N_SW'(1) << spawn_pos) : '0;

    // Per-target lifetime: every surviving lit target ages on a spawn tick;
    // the freshly spawned one starts at 0. Hit bits are already removed from
    // after_hit, so a hit always beats an expiry on the same bit.
    generate
        for (gi = 0; gi < N_SW; gi++) begin : g_tgt
            logic [1:0] age_q;
            logic       age_inc;

            assign age_inc          = spawn_tick && after_hit[gi];
            assign expire_bits[gi]  = age_inc && (age_q == 2'(LIFE_TICKS - 1));
            assign target_d[gi]     = spawn_bits[gi] | (after_hit[gi] & ~expire_bits[gi]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    age_q <= '0;
                end else if (start || !in_play || !target_d[gi] || spawn_bits[gi]) begin
                    age_q <= '0;
                end else if (age_inc) begin
                    age_q <= age_q + 2'd1;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Score / streak next-state
    // ------------------------------------------------------------------
    logic [1:0]         hit_inc;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_d;
    logic               miss_d;

`ifdef STREAK_BONUS_EN
    logic [3:0] streak_q;
    logic [3:0] streak_inc;
    logic [3:0] streak_d;

    always_comb begin
        streak_inc = (streak_q == 4'd15) ? 4'd15 : streak_q + 4'd1;
        // Saturated at 15 the streak no longer "reaches" a multiple of 5.
        if ((streak_q != 4'd15) &&
            (streak_inc == 4'd5 || streak_inc == 4'd10 || streak_inc == 4'd15)) begin
            hit_inc = 2'd2;
        end else begin
            hit_inc = 2'd1;
        end
        streak_d = streak_q;
        if (any_hit) begin
            streak_d = streak_inc;
        end else if (wrong_sw || (|expire_bits)) begin
            streak_d = 4'd0;
        end
    end
`else
    assign hit_inc = 2'd1;
`endif

    assign score_sum = {1'b0, score_q} + {{(SCORE_W - 1){1'b0}}, hit_inc};

    always_comb begin
        score_d = score_q;
        if (any_hit) begin
            score_d = (score_sum > SCORE_CAP) ? SCORE_CAP[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
        end else if (wrong_sw) begin
            score_d = (score_q == '0) ? '0 : score_q - 1'b1;
        end
    end

    assign miss_d = (!any_hit && wrong_sw) || (|expire_bits);

    // ------------------------------------------------------------------
    // Game FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            speed_level_q <= '0;
            target_q      <= '0;
            score_q       <= '0;
            timer_q       <= TIMER_INIT;
            playing_q     <= 1'b0;
            game_over_q   <= 1'b0;
            hit_q         <= 1'b0;
            miss_q        <= 1'b0;
`ifdef STREAK_BONUS_EN
            streak_q      <= '0;
`endif
        end else begin
            speed_level_q <= speed_sel;
            hit_q         <= 1'b0;
            miss_q        <= 1'b0;
            if (start) begin
                // Start from any state, including a restart mid-game.
                state_q     <= S_PLAY;
                target_q    <= '0;
                score_q     <= '0;
                timer_q     <= TIMER_INIT;
                playing_q   <= 1'b1;
                game_over_q <= 1'b0;
`ifdef STREAK_BONUS_EN
                streak_q    <= '0;
`endif
            end else if (state_q == S_PLAY) begin
                target_q <= target_d;
                score_q  <= score_d;
                hit_q    <= any_hit;
                miss_q   <= miss_d;
`ifdef STREAK_BONUS_EN
                streak_q <= streak_d;
`endif
                if (sec_tick) begin
                    if (timer_q <= 6'd1) begin
                        state_q     <= S_OVER;
                        timer_q     <= 6'd0;
                        target_q    <= '0;
                        playing_q   <= 1'b0;
                        game_over_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q - 6'd1;
                    end
                end
            end
        end
    end

    assign target_led  = target_q;
    assign score       = score_q;
    assign timer       = timer_q;
    assign speed_level = speed_level_q;
    assign playing     = playing_q;
    assign game_over   = game_over_q;
    assign hit_pulse   = hit_q;
    assign miss_pulse  = miss_q;
`ifdef STREAK_BONUS_EN
    assign streak      = streak_q;
`else
    assign streak      = 4'd0;
`endif

endmodule

// File: tb/tb_whack_game_core.sv
module tb_whack_game_core;

    localparam int N_SW      = 18;
    localparam int POS_W     = 5;
    localparam int GAME_SECS = 3;
    localparam int LIFE      = 2;
    localparam int SCORE_MAX = 9999;
    localparam int P0        = 2000;  // speed 0 spawn period (cycles, 1 cycle = 1 ms)
    localparam int P3        = 200;   // speed 3 spawn period
`ifdef STREAK_BONUS_EN
    localparam bit BONUS = 1'b1;
`else
    localparam bit BONUS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        speed_sel = 2'd0;
    logic [N_SW-1:0]   sw = '0;
    logic [POS_W-1:0]  rand_pos = '0;
    logic [N_SW-1:0]   target_led;
    logic [13:0]       score;
    logic [5:0]        timer;
    logic [1:0]        speed_level;
    logic              playing;
    logic              game_over;
    logic              hit_pulse;
    logic              miss_pulse;
    logic [3:0]        streak;

    int checks = 0;
    int failures = 0;
    int gcyc = 0;        // posedges since the last start edge
    int exp_score = 0;
    int exp_streak = 0;

    always #5 clk = ~clk;

    whack_game_core #(
        .N_SW(N_SW), .POS_W(POS_W), .CLK_HZ(1000), .GAME_SECS(GAME_SECS),
        .MAX_TGT(2), .LIFE_TICKS(LIFE), .DEBOUNCE_CYC(4),
        .SPD0_MS(P0), .SPD1_MS(1000), .SPD2_MS(500), .SPD3_MS(P3),
        .SCORE_MAX(SCORE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .speed_sel(speed_sel),
        .sw(sw), .rand_pos(rand_pos), .target_led(target_led), .score(score),
        .timer(timer), .speed_level(speed_level), .playing(playing),
        .game_over(game_over), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .streak(streak)
    );

    // ---------------- reference model helpers ----------------
    function automatic int fold(input int r);
        return r % N_SW;
    endfunction

    function automatic logic [N_SW-1:0] onehot(input int p);
        logic [N_SW-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic int raw_of(input int v);
        if (v < 32 - N_SW && $urandom_range(0, 1) == 1) return v + N_SW;
        return v;
    endfunction

    function automatic logic [3:0] exp_streak_port();
        return BONUS ? 4'(exp_streak) : 4'd0;
    endfunction

    task automatic model_hit();
        int prev;
        int inc;
        prev = exp_streak;
        inc = 1;
        exp_streak = (prev == 15) ? 15 : prev + 1;
        if (BONUS && prev != 15 && (exp_streak % 5) == 0) inc = 2;
        exp_score = (exp_score + inc > SCORE_MAX) ? SCORE_MAX : exp_score + inc;
    endtask

    task automatic model_wrong();
        exp_streak = 0;
        if (exp_score > 0) exp_score = exp_score - 1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        gcyc += n;
    endtask

    task automatic wait_to(input int c);
        if (c > gcyc) step(c - gcyc);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        gcyc = 0;
        exp_score = 0;
        exp_streak = 0;
        $display("start speed_sel=%0d", speed_sel);
    endtask

    task automatic press(input int idx, output int nh, output int nm);
        nh = 0;
        nm = 0;
        sw[idx] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) sw[idx] = 1'b0;
            @(negedge clk);
            gcyc++;
            if (hit_pulse) nh++;
            if (miss_pulse) nm++;
        end
        $display("press sw[%0d] hits=%0d misses=%0d score=%0d streak=%0d", idx, nh, nm, score, streak);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (target_led !== '0) begin failures++; $display("FAIL rst_led got=%0h exp=0", target_led); end
        checks++; if (score !== 14'd0) begin failures++; $display("FAIL rst_score got=%0d exp=0", score); end
        checks++; if (timer !== 6'(GAME_SECS)) begin failures++; $display("FAIL rst_timer got=%0d exp=%0d", timer, GAME_SECS); end
        checks++; if (speed_level !== 2'd0) begin failures++; $display("FAIL rst_speed got=%0d exp=0", speed_level); end
        checks++; if ({playing, game_over, hit_pulse, miss_pulse} !== 4'b0) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {playing, game_over, hit_pulse, miss_pulse}); end
        checks++; if (streak !== 4'd0) begin failures++; $display("FAIL rst_streak got=%0d exp=0", streak); end
        rst_n = 1'b1;
        repeat (5000) @(negedge clk);
        checks++; if (playing !== 1'b0 || game_over !== 1'b0) begin failures++; $display("FAIL idle_state got=%b%b exp=00", playing, game_over); end
        checks++; if (target_led !== '0) begin failures++; $display("FAIL idle_led got=%0h exp=0", target_led); end
        checks++; if (timer !== 6'(GAME_SECS)) begin failures++; $display("FAIL idle_timer got=%0d exp=%0d", timer, GAME_SECS); end
        $display("test_reset done");
    endtask

    task automatic test_spawn_hit();
        int nh, nm;
        speed_sel = 2'd0;
        rand_pos = 5'd5;
        do_start();
        checks++; if (playing !== 1'b1) begin failures++; $display("FAIL start_playing got=%b exp=1", playing); end
        checks++; if (timer !== 6'(GAME_SECS)) begin failures++; $display("FAIL start_timer got=%0d exp=%0d", timer, GAME_SECS); end
        wait_to(P0 - 1);
        checks++; if (target_led !== '0) begin failures++; $display("FAIL pre_spawn got=%0h exp=0", target_led); end
        wait_to(P0);
        checks++; if (target_led !== onehot(5)) begin failures++; $display("FAIL spawn5 got=%0h exp=%0h", target_led, onehot(5)); end
        checks++; if (timer !== 6'(GAME_SECS - P0 / 1000)) begin failures++; $display("FAIL timer_2s got=%0d exp=%0d", timer, GAME_SECS - P0 / 1000); end
        press(5, nh, nm);
        model_hit();
        checks++; if (nh !== 1 || nm !== 0) begin failures++; $display("FAIL hit5_pulses got=%0d/%0d exp=1/0", nh, nm); end
        checks++; if (score !== 14'(exp_score)) begin failures++; $display("FAIL hit5_score got=%0d exp=%0d", score, exp_score); end
        checks++; if (target_led !== '0) begin failures++; $display("FAIL hit5_led got=%0h exp=0", target_led); end
    endtask

    task automatic test_game_over();
        int nh, nm, idx;
        wait_to(GAME_SECS * 1000 - 1);
        checks++; if (playing !== 1'b1 || timer !== 6'd1) begin failures++; $display("FAIL last_sec got=%b/%0d exp=1/1", playing, timer); end
        wait_to(GAME_SECS * 1000);
        checks++; if (game_over !== 1'b1 || playing !== 1'b0) begin failures++; $display("FAIL over_flags got=%b%b exp=10", game_over, playing); end
        checks++; if (timer !== 6'd0 || target_led !== '0) begin failures++; $display("FAIL over_clear got=%0d/%0h exp=0/0", timer, target_led); end
        idx = $urandom_range(0, N_SW - 1);
        press(idx, nh, nm);
        checks++; if (score !== 14'(exp_score) || nh + nm != 0) begin failures++; $display("FAIL over_frozen got=%0d/%0d exp=%0d/0", score, nh + nm, exp_score); end
        do_start();
        checks++; if (playing !== 1'b1 || game_over !== 1'b0) begin failures++; $display("FAIL replay_flags got=%b%b exp=10", playing, game_over); end
        checks++; if (score !== 14'd0 || timer !== 6'(GAME_SECS)) begin failures++; $display("FAIL replay_init got=%0d/%0d exp=0/%0d", score, timer, GAME_SECS); end
    endtask

    task automatic test_hits_streak();
        int nh, nm, r, p;
        speed_sel = 2'd3;
        do_start();
        for (int k = 1; k <= 5; k++) begin
            r = $urandom_range(0, 31);
            rand_pos = POS_W'(r);
            p = fold(r);
            wait_to(k * P3 - 1);
            checks++; if (target_led !== '0) begin failures++; $display("FAIL streak_pre k=%0d got=%0h exp=0", k, target_led); end
            wait_to(k * P3);
            checks++; if (target_led !== onehot(p)) begin failures++; $display("FAIL streak_spawn k=%0d raw=%0d got=%0h exp=%0h", k, r, target_led, onehot(p)); end
            press(p, nh, nm);
            model_hit();
            checks++; if (nh !== 1 || nm !== 0) begin failures++; $display("FAIL streak_pulses k=%0d got=%0d/%0d exp=1/0", k, nh, nm); end
            checks++; if (score !== 14'(exp_score)) begin failures++; $display("FAIL streak_score k=%0d got=%0d exp=%0d", k, score, exp_score); end
            checks++; if (streak !== exp_streak_port()) begin failures++; $display("FAIL streak_cnt k=%0d got=%0d exp=%0d", k, streak, exp_streak_port()); end
        end
    endtask

    task automatic test_wrong_switch();
        int nh, nm, r, p, w;
        speed_sel = 2'd3;
        do_start();
        for (int k = 1; k <= 4; k++) begin
            r = $urandom_range(0, 31);
            rand_pos = POS_W'(r);
            p = fold(r);
            wait_to(k * P3);
            checks++; if (target_led !== onehot(p)) begin failures++; $display("FAIL wrong_spawn k=%0d got=%0h exp=%0h", k, target_led, onehot(p)); end
            if (k == 1 || k == 4) begin
                w = (p + 1 + $urandom_range(0, N_SW - 2)) % N_SW;
                press(w, nh, nm);
                model_wrong();
                checks++; if (nh !== 0 || nm !== 1) begin failures++; $display("FAIL wrong_pulses k=%0d got=%0d/%0d exp=0/1", k, nh, nm); end
                checks++; if (score !== 14'(exp_score)) begin failures++; $display("FAIL wrong_score k=%0d got=%0d exp=%0d", k, score, exp_score); end
                checks++; if (target_led !== onehot(p) || streak !== 4'd0) begin failures++; $display("FAIL wrong_keep k=%0d got=%0h/%0d exp=%0h/0", k, target_led, streak, onehot(p)); end
            end
            press(p, nh, nm);
            model_hit();
            checks++; if (score !== 14'(exp_score) || nh !== 1) begin failures++; $display("FAIL wrong_hit k=%0d got=%0d/%0d exp=%0d/1", k, score, nh, exp_score); end
        end
    endtask

    task automatic test_expiry_max();
        int a, b, c;
        speed_sel = 2'd3;
        rand_pos = 5'd20;
        do_start();
        wait_to(P3);
        checks++; if (target_led !== onehot(2)) begin failures++; $display("FAIL fold20 got=%0h exp=%0h", target_led, onehot(2)); end
        wait_to(2 * P3);
        checks++; if (target_led !== onehot(2) || miss_pulse !== 1'b0) begin failures++; $display("FAIL age1 got=%0h/%b exp=%0h/0", target_led, miss_pulse, onehot(2)); end
        wait_to((1 + LIFE) * P3 - 1);
        checks++; if (target_led !== onehot(2)) begin failures++; $display("FAIL pre_expire got=%0h exp=%0h", target_led, onehot(2)); end
        wait_to((1 + LIFE) * P3);
        checks++; if (target_led !== '0 || miss_pulse !== 1'b1) begin failures++; $display("FAIL expire got=%0h/%b exp=0/1", target_led, miss_pulse); end
        step(1);
        checks++; if (miss_pulse !== 1'b0 || score !== 14'd0) begin failures++; $display("FAIL expire_after got=%b/%0d exp=0/0", miss_pulse, score); end
        a = $urandom_range(0, N_SW - 1);
        b = (a + 1 + $urandom_range(0, N_SW - 2)) % N_SW;
        do c = $urandom_range(0, N_SW - 1); while (c == a || c == b);
        rand_pos = POS_W'(raw_of(a));
        wait_to(4 * P3);
        checks++; if (target_led !== onehot(a)) begin failures++; $display("FAIL max_a got=%0h exp=%0h", target_led, onehot(a)); end
        rand_pos = POS_W'(raw_of(b));
        wait_to(5 * P3);
        checks++; if (target_led !== (onehot(a) | onehot(b))) begin failures++; $display("FAIL max_ab got=%0h exp=%0h", target_led, onehot(a) | onehot(b)); end
        rand_pos = POS_W'(raw_of(c));
        wait_to(6 * P3);
        checks++; if (target_led !== onehot(b) || miss_pulse !== 1'b1) begin failures++; $display("FAIL max_full got=%0h/%b exp=%0h/1", target_led, miss_pulse, onehot(b)); end
        wait_to(7 * P3);
        checks++; if (target_led !== onehot(c) || miss_pulse !== 1'b1) begin failures++; $display("FAIL max_c got=%0h/%b exp=%0h/1", target_led, miss_pulse, onehot(c)); end
        $display("expiry a=%0d b=%0d c=%0d led=%0h", a, b, c, target_led);
    endtask

    task automatic test_restart_and_reset();
        int nh, nm;
        speed_sel = 2'd3;
        rand_pos = 5'd7;
        do_start();
        wait_to(P3);
        press(7, nh, nm);
        model_hit();
        rand_pos = 5'd9;
        wait_to(2 * P3 + 10);
        checks++; if (target_led !== onehot(9) || score !== 14'(exp_score)) begin failures++; $display("FAIL pre_restart got=%0h/%0d exp=%0h/%0d", target_led, score, onehot(9), exp_score); end
        do_start();
        checks++; if (score !== 14'd0 || target_led !== '0 || timer !== 6'(GAME_SECS) || streak !== 4'd0) begin failures++; $display("FAIL restart_init got=%0d/%0h/%0d/%0d exp=0/0/%0d/0", score, target_led, timer, streak, GAME_SECS); end
        wait_to(P3 - 1);
        checks++; if (target_led !== '0) begin failures++; $display("FAIL restart_pre got=%0h exp=0", target_led); end
        wait_to(P3);
        checks++; if (target_led !== onehot(9)) begin failures++; $display("FAIL restart_spawn got=%0h exp=%0h", target_led, onehot(9)); end
        press(9, nh, nm);
        model_hit();
        rand_pos = 5'd11;
        wait_to(2 * P3 + 5);
        checks++; if (target_led !== onehot(11) || score !== 14'(exp_score)) begin failures++; $display("FAIL pre_reset got=%0h/%0d exp=%0h/%0d", target_led, score, onehot(11), exp_score); end
        rst_n = 1'b0;
        #1;
        checks++; if (target_led !== '0 || score !== 14'd0 || timer !== 6'(GAME_SECS)) begin failures++; $display("FAIL midreset_vals got=%0h/%0d/%0d exp=0/0/%0d", target_led, score, timer, GAME_SECS); end
        checks++; if (playing !== 1'b0 || speed_level !== 2'd0 || streak !== 4'd0) begin failures++; $display("FAIL midreset_ctl got=%b/%0d/%0d exp=0/0/0", playing, speed_level, streak); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        checks++; if (playing !== 1'b0 || target_led !== '0) begin failures++; $display("FAIL post_reset_idle got=%b/%0h exp=0/0", playing, target_led); end
    endtask

    initial begin
        test_reset();
        test_spawn_hit();
        test_game_over();
        test_hits_streak();
        test_wrong_switch();
        test_expiry_max();
        test_restart_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/whack_game_core.md
Name: whack_game_core

Overview:
Parametrised whack-a-mole game engine for the DE2 board. It replaces the fixed 18-switch, single-target controller. It runs on a single clock with internal clock-enable ticks instead of derived clocks. It supports N switches, multiple concurrent targets with finite lifetime, four speed levels and an explicit start/play/over FSM. The block sits between the switch/key inputs, the LFSR random source, and the LED/7-seg display drivers.

Parameters:
N_SW, 18, number of switch/LED channels (2..32)
POS_W, $clog2(N_SW), width of random position input
CLK_HZ, 50_000_000, clk frequency
GAME_SECS, 60, game length in seconds (max 63)
MAX_TGT, 2, maximum simultaneously lit targets (1..4)
LIFE_TICKS, 2, spawn ticks a target survives unhit (1..3)
DEBOUNCE_CYC, 500_000, stable cycles required by debouncer
SPD0_MS/SPD1_MS/SPD2_MS/SPD3_MS, 2000/1500/1000/750, spawn period per speed level
SCORE_MAX, 9999, score saturation value

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  synchronous start/restart pulse (already debounced KEY)
speed_sel  in  2  requested speed level 0..3
sw  in  N_SW  raw asynchronous switches
rand_pos  in  POS_W  free-running random value
target_led  out  N_SW  lit targets
score  out  14  current score
timer  out  6  seconds remaining
speed_level  out  2  registered active speed level
playing  out  1  FSM in PLAY
game_over  out  1  FSM in OVER
hit_pulse  out  1  one-cycle pulse per scoring hit
miss_pulse  out  1  one-cycle pulse on wrong switch or target expiry
streak  out  4  consecutive-hit count (0 without STREAK_BONUS_EN)

Behaviour:
- Reset values: target_led=0, score=0, timer=GAME_SECS, speed_level=0, playing=0, game_over=0, pulses=0, streak=0. The FSM enters IDLE. All per-target age counters are cleared.
- Ticks:
  - A ms prescaler (CLK_HZ/1000 cycles) drives sec_tick (every 1000 ms) and spawn_tick (every SPDn_MS for the current speed_level).
  - Both tick counters are cleared when the FSM enters PLAY.
- speed_level: loads speed_sel every cycle. The spawn counter is not reset on a change, so the new period applies at the next count compare.
- FSM:
  - IDLE --start--> PLAY. On entry: score=0, timer=GAME_SECS, targets cleared, streak=0.
  - PLAY --sec_tick with timer==1--> OVER. timer goes to 0 and targets are cleared.
  - OVER --start--> PLAY, with the same initialisation as from IDLE.
  - start while in PLAY restarts the game (same initialisation).
  - Only PLAY changes score or targets.
- Timer: decrements by 1 on each sec_tick in PLAY and never wraps below 0.
- Spawn (spawn_tick in PLAY):
  - Position p = rand_pos, or rand_pos-N_SW if rand_pos>=N_SW.
  - If the number of lit targets < MAX_TGT and bit p is unlit, light p with age 0. Otherwise there is no spawn and no retry.
  - On the same tick, every other lit target's age increments. A target reaching LIFE_TICKS is cleared and raises miss_pulse.
- Switch input:
  - Per-channel debouncer: 2-flop sync, then DEBOUNCE_CYC stable cycles before the stable value updates.
  - rise[i] is a one-cycle pulse on a stable 0->1 transition. Falling edges are ignored.
- Scoring (PLAY, per cycle, evaluated against the pre-cycle target_led):
  - If any rise&target: clear those bits, score+1 (saturating at SCORE_MAX), hit_pulse=1, streak+1 (saturating at 15). Hits take priority over wrong switches in the same cycle.
  - Else if any rise&~target: score-1 (saturating at 0), miss_pulse=1, streak=0.
  - Expiry sets streak=0.
- Same-cycle conflicts:
  - Hit and expiry on the same bit: the hit wins.
  - Hit and spawn on the same bit: the bit is cleared and then re-lit by the spawn (age 0).
- Reset mid-game returns immediately to the reset values.

Optional Feature:
STREAK_BONUS_EN
- Defined: a hit that brings streak to a multiple of 5 adds +2 instead of +1 (still saturating). The streak port is driven as described above.
- Undefined: every hit adds +1, the streak logic is absent, and streak is tied to 0.

Decomposition:
- Package whack_pkg:
  - FSM state enum (S_IDLE, S_PLAY, S_OVER).
  - Speed-level typedef.
  - SCORE_W=14.
  - Function ms_to_cycles.
- Sub-module sw_debounce: parameter DEBOUNCE_CYC, single channel, outputs stable and rise. Instantiated N_SW times via generate.

Test Plan:
All scenarios use sim parameters CLK_HZ=1000, DEBOUNCE_CYC=4, GAME_SECS=3, SPD0_MS=2000.
- Reset then no start -> remain in IDLE for 5 s; target_led=0, timer=3, playing=0.
- start, rand_pos=5 -> playing=1. After 2000 cycles target_led=0x20. Raise sw[5] for 10 cycles -> one hit_pulse, score=1, target_led=0.
- Target at bit 5; raise sw[7] with score=0 -> miss_pulse, score stays 0. Repeat with score=3 -> score=2.
- rand_pos=20 with N_SW=18 -> bit 2 lit. Leave unhit 2 further spawn ticks -> cleared with miss_pulse.
- Run to timer=0 -> game_over=1, target_led=0, further switch edges leave score unchanged. Then start -> playing=1, score=0, timer=3.
- With STREAK_BONUS_EN, 5 consecutive hits -> score=6 and streak=5. Without the macro -> score=5 and streak=0.
